// File: rtl/dac_spi_tx_if.sv
// Signal bundle between the audio sample source and the DAC SPI transmitter.
interface dac_spi_tx_if #(
  parameter int W = 25
);
  logic                Enable;
  logic signed [W-1:0] y;
  logic                SCLK;
  logic                SYNC_n;
  logic                DIN;
  logic                Busy;
  logic                Done;
  logic                Overrun;

  modport master (
    output Enable, y,
    input  SCLK, SYNC_n, DIN, Busy, Done, Overrun
  );

  modport slave (
    input  Enable, y,
    output SCLK, SYNC_n, DIN, Busy, Done, Overrun
  );
endinterface

// File: rtl/dac_spi_tx.sv
// Converts each filtered sample to a 12-bit offset-binary code and sends it as a 16-bit SPI frame.
// Define DAC_SAT_EN to clamp out-of-range samples; otherwise the low 12 bits wrap.
module dac_spi_tx #(
  parameter int W    = 25,
  parameter int FRAC = 11,
  parameter int DIV  = 2
) (
  input  logic         CLK,
  input  logic         Reset,
  dac_spi_tx_if.slave  bus
);
  localparam int SH = FRAC - 11;
  localparam int DW = (DIV > 1) ? $clog2(2 * DIV) : 1;
  localparam logic [DW-1:0] DIV_HALF = DW'(DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(2 * DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_END   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   shreg_q, shreg_d;
  logic [3:0]    bit_q, bit_d;
  logic [DW-1:0] div_q, div_d;
  logic          sclk_q, sclk_d;
  logic          sync_n_q, sync_n_d;
  logic          din_q, din_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ovr_q, ovr_d;
  logic [11:0]   code_s;

`ifdef DAC_SAT_EN
  localparam logic signed [W-1:0] S_MAX = W'(2047);
  localparam logic signed [W-1:0] S_MIN = W'(-2048);
  logic signed [W-1:0] s_s;

  assign s_s = bus.y >>> SH;

  always_comb begin
    if (s_s > S_MAX) begin
      code_s = 12'hFFF;
    end else if (s_s < S_MIN) begin
      code_s = 12'h000;
    end else begin
      code_s = {~s_s[11], s_s[10:0]};
    end
  end
`else
  // Wrap mode: the 12-bit window of y after the fractional shift, MSB inverted.
  assign code_s = {~bus.y[SH+11], bus.y[SH+10:SH]};
`endif

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bit_d    = bit_q;
    div_d    = div_q;
    ovr_d    = ovr_q | (bus.Enable & (state_q != ST_IDLE));
    sclk_d   = 1'b1;
    sync_n_d = 1'b1;
    din_d    = 1'b0;
    busy_d   = (state_q != ST_IDLE);
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.Enable) begin
          shreg_d = {4'b0000, code_s};
          bit_d   = 4'd15;
          div_d   = {DW{1'b0}};
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        sync_n_d = 1'b0;
        din_d    = shreg_q[15];
        sclk_d   = (div_q < DIV_HALF);
        if (div_q == DIV_LAST) begin
          shreg_d = {shreg_q[14:0], 1'b0};
          div_d   = {DW{1'b0}};
          bit_d   = bit_q - 4'd1;
          if (bit_q == 4'd0) begin
            state_d = ST_END;
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          div_d = div_q + {{(DW-1){1'b0}}, 1'b1};
        end
      end
      ST_END: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs follow the registered state one cycle later, so the pins see a clean frame.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      shreg_q  <= 16'h0000;
      bit_q    <= 4'd0;
      div_q    <= {DW{1'b0}};
      sclk_q   <= 1'b1;
      sync_n_q <= 1'b1;
      din_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bit_q    <= bit_d;
      div_q    <= div_d;
      sclk_q   <= sclk_d;
      sync_n_q <= sync_n_d;
      din_q    <= din_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
    end
  end

  assign bus.SCLK    = sclk_q;
  assign bus.SYNC_n  = sync_n_q;
  assign bus.DIN     = din_q;
  assign bus.Busy    = busy_q;
  assign bus.Done    = done_q;
  assign bus.Overrun = ovr_q;
endmodule

// File: tb/tb_dac_spi_tx.sv
// Self-checking bench for dac_spi_tx: DIV=2 and DIV=1 instances, frames decoded from the SPI pins.
module tb_dac_spi_tx;
  localparam int W    = 25;
  localparam int FRAC = 11;

  logic CLK   = 1'b0;
  logic Reset = 1'b0;

  dac_spi_tx_if #(.W(W)) b1 ();
  dac_spi_tx_if #(.W(W)) b2 ();

  dac_spi_tx #(.W(W), .FRAC(FRAC), .DIV(1)) dut1 (.CLK(CLK), .Reset(Reset), .bus(b1));
  dac_spi_tx #(.W(W), .FRAC(FRAC), .DIV(2)) dut2 (.CLK(CLK), .Reset(Reset), .bus(b2));

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Index 0 = DIV=1 instance, index 1 = DIV=2 instance.
  logic [1:0] m_sync, m_sclk, m_din;
  assign m_sync = {b2.SYNC_n, b1.SYNC_n};
  assign m_sclk = {b2.SCLK, b1.SCLK};
  assign m_din  = {b2.DIN, b1.DIN};

  logic [15:0] cap_frame [2][64];
  int          cap_bits  [2][64];
  int          cap_low   [2][64];
  int          cap_cnt   [2];
  int          stab      [2];
  logic [1:0]  p_sync, p_sclk, p_din;
  logic [15:0] rx [2];
  int          nb [2];
  int          lowc [2];

  typedef struct {
    logic [W-1:0] y;
    logic [15:0]  frame;
  } vec_t;
  vec_t vecs [8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] model_frame(input logic [W-1:0] yv);
    longint s;
    longint c;
    s = longint'($signed(yv));
    s = s >>> (FRAC - 11);
`ifdef DAC_SAT_EN
    if (s > 2047) s = 2047;
    else if (s < -2048) s = -2048;
    c = s + 2048;
`else
    c = (((s % 4096) + 4096) + 2048) % 4096;
`endif
    return 16'(c);
  endfunction

  function automatic logic [W-1:0] rand_y();
    int sel;
    int v;
    sel = int'($urandom_range(0, 2));
    case (sel)
      0: v = int'($urandom_range(0, 4095)) - 2048;
      1: v = int'($urandom_range(0, 65535)) - 32768;
      default: v = int'($urandom);
    endcase
    return W'(v);
  endfunction

  task automatic pulse(input int inst, input logic [W-1:0] yv);
    @(negedge CLK);
    if (inst == 1) begin
      b2.Enable = 1'b1;
      b2.y = yv;
    end else begin
      b1.Enable = 1'b1;
      b1.y = yv;
    end
    @(negedge CLK);
    b1.Enable = 1'b0;
    b2.Enable = 1'b0;
  endtask

  task automatic check_frame(input int inst, input int idx, input logic [15:0] exp,
                             input int lowexp, input string nm);
    check({nm, "_present"}, 32'(cap_cnt[inst] > idx), 32'd1);
    if (cap_cnt[inst] > idx) begin
      check(nm, 32'(cap_frame[inst][idx]), 32'(exp));
      check({nm, "_bits"}, 32'(cap_bits[inst][idx]), 32'd16);
      check({nm, "_low"}, 32'(cap_low[inst][idx]), 32'(lowexp));
    end
  endtask

  // Pin-level SPI receiver: shifts DIN on each SCLK fall while SYNC_n is low.
  initial begin
    for (int i = 0; i < 2; i++) begin
      p_sync[i] = 1'b1; p_sclk[i] = 1'b1; p_din[i] = 1'b0;
      rx[i] = 16'h0; nb[i] = 0; lowc[i] = 0; cap_cnt[i] = 0; stab[i] = 0;
    end
    forever begin
      @(negedge CLK);
      for (int i = 0; i < 2; i++) begin
        if (m_sync[i] === 1'b0) begin
          lowc[i]++;
          if (p_sclk[i] === 1'b1 && m_sclk[i] === 1'b0) begin
            rx[i] = {rx[i][14:0], m_din[i]};
            nb[i]++;
          end
          if (p_sync[i] === 1'b0 && m_din[i] !== p_din[i] &&
              !(p_sclk[i] === 1'b0 && m_sclk[i] === 1'b1)) stab[i]++;
        end else if (p_sync[i] === 1'b0) begin
          if (cap_cnt[i] < 64) begin
            cap_frame[i][cap_cnt[i]] = rx[i];
            cap_bits[i][cap_cnt[i]]  = nb[i];
            cap_low[i][cap_cnt[i]]   = lowc[i];
            cap_cnt[i]++;
          end
          rx[i] = 16'h0; nb[i] = 0; lowc[i] = 0;
        end
        p_sync[i] = m_sync[i];
        p_sclk[i] = m_sclk[i];
        p_din[i]  = m_din[i];
      end
    end
  end

  initial begin
    logic [W-1:0] ys [8];
    logic [W-1:0] ya;
    int base;

    b1.Enable = 1'b0; b1.y = '0;
    b2.Enable = 1'b0; b2.y = '0;

    vecs[0] = '{y: 25'h0000000, frame: 16'h0800};
    vecs[1] = '{y: 25'h0000400, frame: 16'h0C00};
    vecs[2] = '{y: 25'h1FFFFFF, frame: 16'h07FF};
    vecs[3] = '{y: 25'h00007FF, frame: 16'h0FFF};
    vecs[4] = '{y: 25'h1FFF800, frame: 16'h0000};
`ifdef DAC_SAT_EN
    vecs[5] = '{y: 25'h0002000, frame: 16'h0FFF};
    vecs[6] = '{y: 25'h1FFE000, frame: 16'h0000};
    vecs[7] = '{y: 25'h0000800, frame: 16'h0FFF};
`else
    vecs[5] = '{y: 25'h0002000, frame: 16'h0800};
    vecs[6] = '{y: 25'h1FFE000, frame: 16'h0800};
    vecs[7] = '{y: 25'h0000800, frame: 16'h0000};
`endif

    // Reset values
    #1 Reset = 1'b1;
    #1;
    check("rst_sclk", 32'(b2.SCLK), 32'd1);
    check("rst_sync", 32'(b2.SYNC_n), 32'd1);
    check("rst_din", 32'(b2.DIN), 32'd0);
    check("rst_busy", 32'(b2.Busy), 32'd0);
    check("rst_done", 32'(b2.Done), 32'd0);
    check("rst_ovr", 32'(b2.Overrun), 32'd0);
    check("rst_sync1", 32'(b1.SYNC_n), 32'd1);
    repeat (3) @(negedge CLK);
    Reset = 1'b0;
    repeat (2) @(negedge CLK);

    // Frame timing for DIV=2, y=0
    base = cap_cnt[1];
    pulse(1, 25'h0);
    check("t0_sync", 32'(b2.SYNC_n), 32'd1);
    check("t0_busy", 32'(b2.Busy), 32'd0);
    @(negedge CLK);
    check("t1_sync", 32'(b2.SYNC_n), 32'd0);
    check("t1_busy", 32'(b2.Busy), 32'd1);
    check("t1_sclk", 32'(b2.SCLK), 32'd1);
    repeat (63) @(negedge CLK);
    check("t64_sync", 32'(b2.SYNC_n), 32'd0);
    check("t64_done", 32'(b2.Done), 32'd0);
    @(negedge CLK);
    check("t65_done", 32'(b2.Done), 32'd1);
    check("t65_sync", 32'(b2.SYNC_n), 32'd1);
    check("t65_busy", 32'(b2.Busy), 32'd1);
    check("t65_sclk", 32'(b2.SCLK), 32'd1);
    @(negedge CLK);
    check("t66_done", 32'(b2.Done), 32'd0);
    check("t66_busy", 32'(b2.Busy), 32'd0);
    repeat (4) @(negedge CLK);
    check_frame(1, base, 16'h0800, 64, "t_frame");

    // Table-driven conversion vectors
    for (int i = 0; i < 8; i++) begin
      base = cap_cnt[1];
      pulse(1, vecs[i].y);
      repeat (70) @(negedge CLK);
      check_frame(1, base, vecs[i].frame, 64, $sformatf("tbl%0d", i));
    end

    // Random samples at the minimum 66-cycle spacing on DIV=2
    base = cap_cnt[1];
    for (int i = 0; i < 8; i++) begin
      ys[i] = rand_y();
      if (i > 0) repeat (64) @(negedge CLK);
      pulse(1, ys[i]);
    end
    repeat (70) @(negedge CLK);
    check("r2_ovr", 32'(b2.Overrun), 32'd0);
    for (int i = 0; i < 8; i++) check_frame(1, base + i, model_frame(ys[i]), 64, $sformatf("r2_%0d", i));

    // Random samples at the minimum 34-cycle spacing on DIV=1
    base = cap_cnt[0];
    for (int i = 0; i < 8; i++) begin
      ys[i] = rand_y();
      if (i > 0) repeat (32) @(negedge CLK);
      pulse(0, ys[i]);
    end
    repeat (40) @(negedge CLK);
    check("r1_ovr", 32'(b1.Overrun), 32'd0);
    for (int i = 0; i < 8; i++) check_frame(0, base + i, model_frame(ys[i]), 32, $sformatf("r1_%0d", i));

    // One cycle too early on DIV=1: second sample hits END and is dropped
    base = cap_cnt[0];
    ya = rand_y();
    pulse(0, ya);
    repeat (31) @(negedge CLK);
    pulse(0, rand_y());
    repeat (40) @(negedge CLK);
    check("e1_ovr", 32'(b1.Overrun), 32'd1);
    check("e1_count", 32'(cap_cnt[0] - base), 32'd1);
    check_frame(0, base, model_frame(ya), 32, "e1_frame");

    // Overrun 10 cycles into a DIV=2 frame
    base = cap_cnt[1];
    pulse(1, 25'h0000400);
    repeat (8) @(negedge CLK);
    check("ov_pre", 32'(b2.Overrun), 32'd0);
    pulse(1, 25'h1FFFFFF);
    check("ov_set", 32'(b2.Overrun), 32'd1);
    repeat (130) @(negedge CLK);
    check("ov_count", 32'(cap_cnt[1] - base), 32'd1);
    check_frame(1, base, 16'h0C00, 64, "ov_frame");
    check("ov_hold", 32'(b2.Overrun), 32'd1);

    // Asynchronous reset during bit 5 of a DIV=2 frame
    base = cap_cnt[1];
    ya = 25'h0000555;
    pulse(1, ya);
    repeat (42) @(negedge CLK);
    check("mr_pre_sync", 32'(b2.SYNC_n), 32'd0);
    #2 Reset = 1'b1;
    #1;
    check("mr_sclk", 32'(b2.SCLK), 32'd1);
    check("mr_sync", 32'(b2.SYNC_n), 32'd1);
    check("mr_din", 32'(b2.DIN), 32'd0);
    check("mr_busy", 32'(b2.Busy), 32'd0);
    check("mr_done", 32'(b2.Done), 32'd0);
    check("mr_ovr2", 32'(b2.Overrun), 32'd0);
    check("mr_ovr1", 32'(b1.Overrun), 32'd0);
    repeat (3) @(negedge CLK);
    Reset = 1'b0;
    check("mr_count", 32'(cap_cnt[1] - base), 32'd1);
    if (cap_cnt[1] > base) begin
      check("mr_bits", 32'(cap_bits[1][base]), 32'd10);
      check("mr_partial", 32'(cap_frame[1][base]), 32'({6'b0, model_frame(ya)} >> 6));
    end
    base = cap_cnt[1];
    pulse(1, 25'h0000400);
    repeat (70) @(negedge CLK);
    check_frame(1, base, 16'h0C00, 64, "mr_after");

    check("stable_din2", 32'(stab[1]), 32'd0);
    check("stable_din1", 32'(stab[0]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
